// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - rx_state_e   : receive FSM states
//   - REG_RXDATA / REG_STATUS : APB register offsets (padd[3:0])
//   - STAT_*       : bit positions inside the STATUS register
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   localparam logic [3:0] REG_RXDATA = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;

   localparam int STAT_VALID   = 0;
   localparam int STAT_PARITY  = 1;
   localparam int STAT_FRAME   = 2;
   localparam int STAT_OVERRUN = 3;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial input into the pclk domain and flags the
// falling edge that marks a potential start bit.
// Ports:
//   pclk      in   clock
//   rst_n     in   asynchronous active-low reset
//   rx_async  in   raw serial line (idles high)
//   rx_sync   out  synchronised serial line (2-flop delay)
//   rx_fall   out  one-cycle pulse when rx_sync goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic pclk,
   input  logic rst_n,
   input  logic rx_async,
   output logic rx_sync,
   output logic rx_fall
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Two-stage synchroniser followed by a history flop for edge detection.
   // Everything resets to the idle-high level so releasing reset can never
   // look like a start edge.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx_async;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Falling edge: the previous synchronised sample was high, the current is low.
   always_comb begin
      rx_sync = sync2_q;
      rx_fall = prev_q & ~sync2_q;
   end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Oversampling UART receiver with an APB register interface. A frame is
// start(0), DATA_BITS data bits LSB first, even parity bit, stop(1). Every
// frame is committed to RXDATA with sticky parity/frame/overrun flags.
// Parameters:
//   CLKS_PER_BIT  pclk cycles per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame (<= 32)
// Ports:
//   pclk, rst_n            clock, asynchronous active-low reset
//   psel, penable, pwrite  APB control
//   padd                   APB byte address, only [3:0] decoded
//   pwdata                 APB write data (STATUS write-1-clear)
//   prdata, pready, pslverr APB response (zero wait states)
//   i_rx_serial            asynchronous serial input
//   o_rx_valid             unread word present in RXDATA
//   o_rx_err               any sticky error flag set
// Register map: 0x0 RXDATA (RO, read clears valid)
//               0x4 STATUS {overrun, frame_err, parity_err, valid}, [3:1] W1C
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 32
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] padd,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        i_rx_serial,
   output logic        o_rx_valid,
   output logic        o_rx_err
);

   import uart_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic                 rxSync;
   logic                 rxFall;

   rx_state_e            rxState_q, rxState_d;
   logic [CW-1:0]        bitCnt_q,  bitCnt_d;
   logic [IW-1:0]        bitIdx_q,  bitIdx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 parAcc_q,  parAcc_d;
   logic                 parMis_q,  parMis_d;
   logic                 commit;
   logic                 stopBad;

   logic [DATA_BITS-1:0] rxData_q,  rxData_d;
   logic                 valid_q,   valid_d;
   logic                 parErr_q,  parErr_d;
   logic                 frmErr_q,  frmErr_d;
   logic                 ovr_q,     ovr_d;

   logic                 apbAccess;
   logic [3:0]           regOff;
   logic                 rdRxData;
   logic                 wrStatus;
   logic                 unusedBits;

   uart_rx_sync uSync (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .rx_async (i_rx_serial),
      .rx_sync  (rxSync),
      .rx_fall  (rxFall)
   );

   // Receive FSM state, counters and shift register. Reset mid-frame simply
   // returns to IDLE; nothing is committed.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rxState_q <= RX_IDLE;
         bitCnt_q  <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
         parAcc_q  <= 1'b0;
         parMis_q  <= 1'b0;
      end else begin
         rxState_q <= rxState_d;
         bitCnt_q  <= bitCnt_d;
         bitIdx_q  <= bitIdx_d;
         shift_q   <= shift_d;
         parAcc_q  <= parAcc_d;
         parMis_q  <= parMis_d;
      end
   end

   // Next-state logic. The start bit is checked half a bit after the edge,
   // then every later sample lands a full bit period further on, i.e. in the
   // middle of each bit. commit is raised in the stop-bit sample cycle so the
   // register file updates on the edge that ends it.
   always_comb begin
      rxState_d = rxState_q;
      bitCnt_d  = bitCnt_q;
      bitIdx_d  = bitIdx_q;
      shift_d   = shift_q;
      parAcc_d  = parAcc_q;
      parMis_d  = parMis_q;
      commit    = 1'b0;
      stopBad   = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            if (rxFall) begin
               bitCnt_d  = '0;
               rxState_d = RX_START;
            end
         end
         RX_START: begin
            if (bitCnt_q == CNT_HALF) begin
               bitCnt_d = '0;
               if (!rxSync) begin
                  rxState_d = RX_DATA;
                  bitIdx_d  = '0;
                  parAcc_d  = 1'b0;
               end else begin
                  rxState_d = RX_IDLE;
               end
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (bitCnt_q == CNT_FULL) begin
               bitCnt_d          = '0;
               shift_d[bitIdx_q] = rxSync;
               parAcc_d          = parAcc_q ^ rxSync;
               if (bitIdx_q == IDX_LAST) begin
                  rxState_d = RX_PARITY;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (bitCnt_q == CNT_FULL) begin
               bitCnt_d  = '0;
               parMis_d  = rxSync ^ parAcc_q;
               rxState_d = RX_STOP;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (bitCnt_q == CNT_FULL) begin
               bitCnt_d  = '0;
               commit    = 1'b1;
               stopBad   = ~rxSync;
               rxState_d = RX_IDLE;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         default: begin
            rxState_d = RX_IDLE;
         end
      endcase
   end

   // APB decode. Side effects only happen in the access phase.
   always_comb begin
      apbAccess = psel & penable;
      regOff    = padd[3:0];
      rdRxData  = apbAccess & ~pwrite & (regOff == REG_RXDATA);
      wrStatus  = apbAccess &  pwrite & (regOff == REG_STATUS);
   end

   // Register file holding the committed word and sticky flags.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rxData_q <= '0;
         valid_q  <= 1'b0;
         parErr_q <= 1'b0;
         frmErr_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         rxData_q <= rxData_d;
         valid_q  <= valid_d;
         parErr_q <= parErr_d;
         frmErr_q <= frmErr_d;
         ovr_q    <= ovr_d;
      end
   end

   // Clears are applied first and the commit afterwards, so a commit always
   // wins against a same-cycle W1C or RXDATA read. A read that coincides with
   // the commit has consumed the old word, so it does not count as overrun.
   always_comb begin
      rxData_d = rxData_q;
      valid_d  = valid_q;
      parErr_d = parErr_q;
      frmErr_d = frmErr_q;
      ovr_d    = ovr_q;
      if (wrStatus) begin
         if (pwdata[STAT_PARITY])  parErr_d = 1'b0;
         if (pwdata[STAT_FRAME])   frmErr_d = 1'b0;
         if (pwdata[STAT_OVERRUN]) ovr_d    = 1'b0;
      end
      if (rdRxData) begin
         valid_d = 1'b0;
      end
      if (commit) begin
         rxData_d = shift_q;
         valid_d  = 1'b1;
         if (parMis_q)             parErr_d = 1'b1;
         if (stopBad)              frmErr_d = 1'b1;
         if (valid_q && !rdRxData) ovr_d    = 1'b1;
      end
   end

   // Read mux and response. prdata/pslverr are held at zero outside the
   // access phase so the bus is quiet when the slave is not addressed.
   always_comb begin
      pready  = apbAccess;
      prdata  = '0;
      pslverr = 1'b0;
      if (apbAccess) begin
         case (regOff)
            REG_RXDATA: prdata = 32'(rxData_q);
            REG_STATUS: begin
               prdata[STAT_VALID]   = valid_q;
               prdata[STAT_PARITY]  = parErr_q;
               prdata[STAT_FRAME]   = frmErr_q;
               prdata[STAT_OVERRUN] = ovr_q;
            end
            default:    pslverr = 1'b1;
         endcase
      end
   end

   // Status outputs and the bits of the bus that carry no meaning here.
   always_comb begin
      o_rx_valid = valid_q;
      o_rx_err   = parErr_q | frmErr_q | ovr_q;
      unusedBits = &{1'b0, padd[31:4], pwdata[31:4], pwdata[STAT_VALID]};
   end

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver. A register-level model tracks what the
// receiver must hold (word, valid, three sticky flags) and when each frame
// must land; a per-cycle compare process checks the DUT against it, and the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int CPB       = 8;
   localparam int NBITS     = 32;
   localparam int FRAME_CYC = (NBITS + 3) * CPB;
   // Edges from driving the start bit to the commit edge: 2 synchroniser
   // stages, one edge into START, half a bit to mid-start, 34 full bits to
   // mid-stop, then the commit edge.
   localparam int COMMIT_LAT = 2 + 1 + CPB / 2 + (NBITS + 2) * CPB;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] padd = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        rxSer = 1'b1;
   logic        oValid;
   logic        oErr;

   int          assertCount = 0;
   int          failCount   = 0;
   bit          checkEn     = 1'b0;

   // Model state
   int          cyc = 0;
   logic [31:0] mData = '0;
   bit          mValid = 0, mPar = 0, mFrm = 0, mOvr = 0;
   bit          pendActive = 0;
   int          pendCycle = 0;
   logic [31:0] pendData = '0;
   bit          pendPar = 0, pendFrm = 0;

   logic [31:0] rdVal;
   logic        rdErr;

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(NBITS)) dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .padd        (padd),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr),
      .i_rx_serial (rxSer),
      .o_rx_valid  (oValid),
      .o_rx_err    (oErr)
   );

   always #5 pclk = ~pclk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [3:0] a);
      case (a)
         4'h0:    return mData;
         4'h4:    return {28'd0, mOvr, mFrm, mPar, mValid};
         default: return 32'd0;
      endcase
   endfunction

   // Register-level model: frame commit at its predicted edge, RXDATA read
   // clears valid, STATUS write clears flags; a commit overrides both.
   always @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         mData = '0; mValid = 0; mPar = 0; mFrm = 0; mOvr = 0;
         pendActive = 0;
      end else begin
         bit acc, rdHit, wHit, doCommit;
         cyc      = cyc + 1;
         acc      = psel && penable;
         rdHit    = acc && !pwrite && (padd[3:0] == 4'h0);
         wHit     = acc &&  pwrite && (padd[3:0] == 4'h4);
         doCommit = pendActive && (cyc == pendCycle);
         if (wHit && pwdata[1]) mPar = 0;
         if (wHit && pwdata[2]) mFrm = 0;
         if (wHit && pwdata[3]) mOvr = 0;
         if (doCommit) begin
            if (mValid && !rdHit) mOvr = 1;
            if (pendPar) mPar = 1;
            if (pendFrm) mFrm = 1;
            mData      = pendData;
            mValid     = 1;
            pendActive = 0;
         end else if (rdHit) begin
            mValid = 0;
         end
      end
   end

   // Per-cycle compare of every DUT output against the model.
   always @(negedge pclk) begin
      if (checkEn) begin
         checkOutput("o_rx_valid", 32'(oValid), 32'(mValid));
         checkOutput("o_rx_err", 32'(oErr), 32'(mPar | mFrm | mOvr));
         checkOutput("pready", 32'(pready), 32'(psel & penable));
         if (psel && penable) begin
            checkOutput("pslverr", 32'(pslverr),
                        32'(!((padd[3:0] == 4'h0) || (padd[3:0] == 4'h4))));
            if (!pwrite) checkOutput("prdata", prdata, modelRead(padd[3:0]));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // Sends one frame starting now (just after an edge). abortAt != 0 stops
   // driving after that many cycles and leaves the line idle.
   task automatic applyStimulus(input logic [31:0] data, input logic parBit,
                                input logic stopBit, input int abortAt);
      logic [34:0] fb;
      fb         = {stopBit, parBit, data, 1'b0};
      pendData   = data;
      pendPar    = ((^data) != parBit);
      pendFrm    = !stopBit;
      pendCycle  = cyc + COMMIT_LAT;
      pendActive = 1;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if (abortAt != 0 && i == abortAt) break;
         rxSer = fb[i / CPB];
         @(posedge pclk);
         #1;
      end
      rxSer = 1'b1;
   endtask

   task automatic apbWrite(input logic [31:0] a, input logic [31:0] d);
      psel = 1; pwrite = 1; padd = a; pwdata = d; penable = 0;
      @(posedge pclk); #1;
      penable = 1;
      @(posedge pclk); #1;
      psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic apbRead(input logic [31:0] a, output logic [31:0] d, output logic e);
      psel = 1; pwrite = 0; padd = a; penable = 0;
      @(posedge pclk); #1;
      penable = 1;
      @(negedge pclk);
      d = prdata;
      e = pslverr;
      @(posedge pclk); #1;
      psel = 0; penable = 0;
   endtask

   initial begin
      $display("[TB] uart_receiver directed test");
      rst_n = 1'b0;
      idle(3);
      @(negedge pclk);
      checkOutput("reset o_rx_valid", 32'(oValid), 32'd0);
      checkOutput("reset o_rx_err", 32'(oErr), 32'd0);
      checkOutput("reset prdata", prdata, 32'd0);
      checkOutput("reset pready", 32'(pready), 32'd0);
      checkOutput("reset pslverr", 32'(pslverr), 32'd0);
      @(posedge pclk); #1;
      rst_n   = 1'b1;
      checkEn = 1'b1;
      idle(4);

      // Clean frame
      applyStimulus(32'hA5A5_0F0F, 1'b0, 1'b1, 0);
      idle(3);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("clean status before", rdVal, 32'h1);
      apbRead(32'h0, rdVal, rdErr);  checkOutput("clean rxdata", rdVal, 32'hA5A5_0F0F);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("clean status after", rdVal, 32'h0);

      // Parity error, then W1C of the parity flag
      applyStimulus(32'h0000_0001, 1'b0, 1'b1, 0);
      idle(3);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("parity status", rdVal, 32'h3);
      apbWrite(32'h4, 32'h2);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("parity w1c status", rdVal, 32'h1);
      apbRead(32'h0, rdVal, rdErr);  checkOutput("parity rxdata", rdVal, 32'h1);

      // Frame error: stop bit 0, word still committed
      applyStimulus(32'h1234_5678, 1'b1, 1'b0, 0);
      idle(3);
      checkOutput("frame o_rx_err", 32'(oErr), 32'd1);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("frame status", rdVal, 32'h5);
      apbRead(32'h0, rdVal, rdErr);  checkOutput("frame rxdata", rdVal, 32'h1234_5678);
      apbWrite(32'h4, 32'h4);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("frame w1c status", rdVal, 32'h0);

      // Overrun: two back-to-back frames, no read in between
      applyStimulus(32'h0000_0001, 1'b1, 1'b1, 0);
      applyStimulus(32'h0000_0002, 1'b1, 1'b1, 0);
      idle(3);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("overrun status", rdVal, 32'h9);
      apbRead(32'h0, rdVal, rdErr);  checkOutput("overrun rxdata", rdVal, 32'h2);
      apbWrite(32'h4, 32'h8);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("overrun w1c status", rdVal, 32'h0);

      // RXDATA read landing on the commit edge of the next frame
      applyStimulus(32'h0000_0003, 1'b0, 1'b1, 0);
      fork
         applyStimulus(32'h0000_0004, 1'b1, 1'b1, 0);
         begin
            idle(COMMIT_LAT - 2);
            apbRead(32'h0, rdVal, rdErr);
            checkOutput("commit-read old word", rdVal, 32'h3);
         end
      join
      idle(3);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("commit-read status", rdVal, 32'h1);
      apbRead(32'h0, rdVal, rdErr);  checkOutput("commit-read new word", rdVal, 32'h4);

      // Glitch shorter than half a bit is rejected
      rxSer = 1'b0;
      idle(CPB / 2 - 2);
      rxSer = 1'b1;
      idle(40);
      checkOutput("glitch o_rx_valid", 32'(oValid), 32'd0);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("glitch status", rdVal, 32'h0);

      // Unmapped address
      apbRead(32'h8, rdVal, rdErr);
      checkOutput("unmapped pslverr", 32'(rdErr), 32'd1);
      checkOutput("unmapped prdata", rdVal, 32'h0);

      // Reset mid-DATA with flags set, then a clean frame
      applyStimulus(32'h0000_0001, 1'b0, 1'b1, 0);
      idle(3);
      applyStimulus(32'h0000_0055, 1'b0, 1'b1, 100);
      rst_n = 1'b0;
      idle(2);
      @(negedge pclk);
      checkOutput("midreset o_rx_valid", 32'(oValid), 32'd0);
      checkOutput("midreset o_rx_err", 32'(oErr), 32'd0);
      @(posedge pclk); #1;
      rst_n = 1'b1;
      idle(5);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("post-reset status", rdVal, 32'h0);
      applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b1, 0);
      idle(3);
      apbRead(32'h0, rdVal, rdErr);  checkOutput("post-reset rxdata", rdVal, 32'hDEAD_BEEF);
      apbRead(32'h4, rdVal, rdErr);  checkOutput("post-reset status after", rdVal, 32'h0);

      idle(2);
      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
